// File: rtl/logic_capture_sequencer_if.sv
// Control/status bundle between the host-side controller and the capture sequencer.
// The master drives capture requests and pod status; the slave (sequencer) drives pod controls.
interface logic_capture_sequencer_if #(
    parameter int NUM_PODS = 2,
    parameter int CNT_W    = 32
);
    logic [NUM_PODS-1:0] pod_enable;
    logic [NUM_PODS-1:0] pod_ready;
    logic                ram_ready;
    logic                arm;
    logic                abort;
    logic                force_trig;
    logic                trig_mode;
    logic [NUM_PODS-1:0] trig_in;
    logic [CNT_W-1:0]    pretrig_len;
    logic [CNT_W-1:0]    posttrig_len;
    logic [NUM_PODS-1:0] flush_complete;
    logic [NUM_PODS-1:0] trig_rst;
    logic [NUM_PODS-1:0] capture_en;
    logic [NUM_PODS-1:0] capture_flush;
    logic                trig_rst_arbiter;
    logic                flush_arbiter;
    logic                busy;
    logic                done;
    logic                timeout_err;
    logic                link_err;
    logic [CNT_W-1:0]    trig_pos;
    logic [2:0]          state;

    modport master (
        output pod_enable, pod_ready, ram_ready, arm, abort, force_trig, trig_mode,
               trig_in, pretrig_len, posttrig_len, flush_complete,
        input  trig_rst, capture_en, capture_flush, trig_rst_arbiter, flush_arbiter,
               busy, done, timeout_err, link_err, trig_pos, state
    );

    modport slave (
        input  pod_enable, pod_ready, ram_ready, arm, abort, force_trig, trig_mode,
               trig_in, pretrig_len, posttrig_len, flush_complete,
        output trig_rst, capture_en, capture_flush, trig_rst_arbiter, flush_arbiter,
               busy, done, timeout_err, link_err, trig_pos, state
    );
endinterface

// File: rtl/logic_capture_sequencer.sv
// Arm/reset/pre-fill/trigger/post-count/flush sequencer for NUM_PODS capture datapaths.
// Timers are down-counters; every output is registered from the current state.
//
// state   | meaning
// IDLE  0 | waiting for an accepted arm
// RST   1 | pods and arbiter held in reset for RST_CYCLES
// PRE   2 | pre-trigger fill, triggers ignored
// WAIT  3 | capturing, waiting for combined or forced trigger
// POST  4 | post-trigger capture count
// FLUSH 5 | flush requested, gathering flush_complete or timing out
// DONE  6 | one-cycle completion
module logic_capture_sequencer #(
    parameter int NUM_PODS      = 2,
    parameter int CNT_W         = 32,
    parameter int RST_CYCLES    = 16,
    parameter int FLUSH_TIMEOUT = 4096
) (
    input logic                      clk_ram_2x,
    input logic                      rst,
    logic_capture_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_PRE   = 3'd2,
        S_WAIT  = 3'd3,
        S_POST  = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_TIMEOUT - 1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    tmr, tmr_nx, pre_q, post_q, pre_load, post_load;
    logic [CNT_W-1:0]    pos_cnt, pos_inc, trig_pos_q;
    logic [NUM_PODS-1:0] en_q, seen, trig_rst_q, capture_en_q, capture_flush_q;
    logic                trig_arb_q, flush_arb_q, busy_q, done_q, timeout_q, link_q;
    logic                accept, trig_hit, flush_enter, flush_tmo, link_lost;
    logic                link_bad, trig, all_seen;

    assign link_bad  = (en_q & ~bus.pod_ready) != '0;
    assign trig      = bus.force_trig |
                       (bus.trig_mode ? &(bus.trig_in | ~en_q) : |(bus.trig_in & en_q));
    // A completion arriving in the current cycle counts, so it wins over a same-cycle timeout.
    assign all_seen  = &(seen | bus.flush_complete | ~en_q);
    assign pos_inc   = (pos_cnt == '1) ? pos_cnt : pos_cnt + CNT_W'(1);
    assign pre_load  = (pre_q == '0) ? '0 : pre_q - CNT_W'(1);
    assign post_load = (post_q == '0) ? '0 : post_q - CNT_W'(1);

    always_comb begin
        state_nx    = state;
        tmr_nx      = (tmr == '0) ? tmr : tmr - CNT_W'(1);
        accept      = 1'b0;
        trig_hit    = 1'b0;
        flush_enter = 1'b0;
        flush_tmo   = 1'b0;
        link_lost   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.arm && bus.ram_ready && bus.pod_enable != '0 &&
                    (bus.pod_enable & ~bus.pod_ready) == '0) begin
                    accept   = 1'b1;
                    state_nx = S_RST;
                    tmr_nx   = RST_LOAD;
                end
            end
            S_RST: begin
                if (bus.abort) begin
                    state_nx = S_IDLE;
                end else if (tmr == '0) begin
                    state_nx = S_PRE;
                    tmr_nx   = pre_load;
                end
            end
            S_PRE, S_WAIT, S_POST: begin
                // Abort and link loss take priority over trigger and timer expiry.
                if (bus.abort || link_bad) begin
                    flush_enter = 1'b1;
                    link_lost   = link_bad;
                end else if (state == S_PRE && tmr == '0) begin
                    state_nx = S_WAIT;
                end else if (state == S_WAIT && trig) begin
                    state_nx = S_POST;
                    trig_hit = 1'b1;
                    tmr_nx   = post_load;
                end else if (state == S_POST && tmr == '0) begin
                    flush_enter = 1'b1;
                end
            end
            S_FLUSH: begin
                if (all_seen) begin
                    state_nx = S_DONE;
                end else if (tmr == '0) begin
                    state_nx  = S_DONE;
                    flush_tmo = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush_enter) begin
            state_nx = S_FLUSH;
            tmr_nx   = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk_ram_2x or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            tmr             <= '0;
            pre_q           <= '0;
            post_q          <= '0;
            pos_cnt         <= '0;
            trig_pos_q      <= '0;
            en_q            <= '0;
            seen            <= '0;
            trig_rst_q      <= '0;
            capture_en_q    <= '0;
            capture_flush_q <= '0;
            trig_arb_q      <= 1'b0;
            flush_arb_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            link_q          <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
            if (accept) begin
                en_q       <= bus.pod_enable;
                pre_q      <= bus.pretrig_len;
                post_q     <= bus.posttrig_len;
                pos_cnt    <= '0;
                trig_pos_q <= '0;
                timeout_q  <= 1'b0;
                link_q     <= 1'b0;
            end
            if (state == S_PRE || state == S_WAIT) pos_cnt <= pos_inc;
            if (trig_hit) trig_pos_q <= pos_inc;
            if (link_lost) link_q <= 1'b1;
            if (flush_tmo) timeout_q <= 1'b1;
            if (flush_enter) seen <= '0;
            else if (state == S_FLUSH) seen <= seen | (bus.flush_complete & en_q);

            trig_rst_q      <= (state == S_RST) ? en_q : '0;
            trig_arb_q      <= (state == S_RST);
            capture_en_q    <= (state == S_PRE || state == S_WAIT || state == S_POST) ? en_q : '0;
            capture_flush_q <= (state == S_FLUSH) ? (en_q & ~seen) : '0;
            flush_arb_q     <= (state == S_FLUSH);
            busy_q          <= (state != S_IDLE);
            done_q          <= (state == S_DONE);
        end
    end

    assign bus.trig_rst         = trig_rst_q;
    assign bus.capture_en       = capture_en_q;
    assign bus.capture_flush    = capture_flush_q;
    assign bus.trig_rst_arbiter = trig_arb_q;
    assign bus.flush_arbiter    = flush_arb_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.timeout_err      = timeout_q;
    assign bus.link_err         = link_q;
    assign bus.trig_pos         = trig_pos_q;
    assign bus.state            = state;
endmodule

// File: tb/tb_logic_capture_sequencer.sv
// Scenario bench for logic_capture_sequencer: capture results are queued when a capture is
// armed and popped when the done pulse appears.
module tb_logic_capture_sequencer;
    localparam int NP = 2;
    localparam int CW = 32;

    logic clk_ram_2x = 1'b0;
    logic rst = 1'b1;
    always #5 clk_ram_2x = ~clk_ram_2x;

    logic_capture_sequencer_if #(.NUM_PODS(NP), .CNT_W(CW)) bus ();

    logic_capture_sequencer #(
        .NUM_PODS(NP), .CNT_W(CW), .RST_CYCLES(16), .FLUSH_TIMEOUT(64)
    ) dut (
        .clk_ram_2x(clk_ram_2x),
        .rst       (rst),
        .bus       (bus.slave)
    );

    typedef struct packed {
        logic [CW-1:0] pos;
        logic          tmo;
        logic          lnk;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic res_t mk(input int pos, input logic tmo, input logic lnk);
        res_t r;
        r.pos = CW'(pos);
        r.tmo = tmo;
        r.lnk = lnk;
        return r;
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({bus.trig_rst, bus.capture_en, bus.capture_flush, bus.trig_rst_arbiter,
                    bus.flush_arbiter, bus.busy, bus.done, bus.timeout_err, bus.link_err,
                    bus.trig_pos, bus.state});
    endfunction

    task automatic tick();
        @(posedge clk_ram_2x);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pod_enable     = '0;
        bus.pod_ready      = '1;
        bus.ram_ready      = 1'b1;
        bus.arm            = 1'b0;
        bus.abort          = 1'b0;
        bus.force_trig     = 1'b0;
        bus.trig_mode      = 1'b0;
        bus.trig_in        = '0;
        bus.pretrig_len    = '0;
        bus.posttrig_len   = '0;
        bus.flush_complete = '0;
    endtask

    task automatic start(input logic [NP-1:0] en, input int pre, input int post);
        bus.pod_enable   = en;
        bus.pretrig_len  = CW'(pre);
        bus.posttrig_len = CW'(post);
        bus.arm          = 1'b1;
        tick();
        bus.arm          = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output res_t got);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done === 1'b1) begin
                ok  = 1'b1;
                got = {bus.trig_pos, bus.timeout_err, bus.link_err};
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        total++;
        if (out_vec() !== 64'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", out_vec());
        end
        #2 rst = 1'b0;
        tick();
        total++;
        if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle got state=%0d busy=%0b want 0/0", bus.state, bus.busy);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        res_t got, exp;
        int   n_rst, n_tr, n;
        bus.trig_mode = 1'b0;
        start(2'b11, 10, 20);
        exp_q.push_back(mk(15, 1'b0, 1'b0));
        bus.pod_enable = 2'b01;
        n_rst = 0;
        n_tr  = 0;
        for (int i = 0; i < 40 && bus.state != 3'd2; i++) begin
            if (bus.state == 3'd1) n_rst++;
            if (bus.trig_rst == 2'b11 && bus.trig_rst_arbiter) n_tr++;
            tick();
        end
        if (bus.trig_rst == 2'b11 && bus.trig_rst_arbiter) n_tr++;
        total++;
        if (n_rst != 16) begin bad++; $display("FAIL basic_rst_state_cycles got=%0d want=16", n_rst); end
        total++;
        if (n_tr != 16) begin bad++; $display("FAIL basic_trig_rst_cycles got=%0d want=16", n_tr); end
        tick();
        total++;
        if (bus.trig_rst !== 2'b00 || bus.capture_en !== 2'b11) begin
            bad++; $display("FAIL basic_pre_outputs got rst=%b cen=%b want 00/11", bus.trig_rst, bus.capture_en);
        end
        wait_state(3'd3, 30, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_reach_wait got=%0d want=3", bus.state); end
        repeat (4) tick();
        bus.trig_in = 2'b10;
        tick();
        bus.trig_in = 2'b00;
        n = 0;
        while (bus.state == 3'd4 && n < 100) begin n++; tick(); end
        total++;
        if (n != 20) begin bad++; $display("FAIL basic_post_cycles got=%0d want=20", n); end
        total++;
        if (bus.state !== 3'd5) begin bad++; $display("FAIL basic_flush_state got=%0d want=5", bus.state); end
        tick();
        total++;
        if (bus.capture_flush !== 2'b11 || bus.flush_arbiter !== 1'b1 || bus.capture_en !== 2'b00) begin
            bad++; $display("FAIL basic_flush_outputs got cf=%b fa=%b cen=%b want 11/1/00",
                            bus.capture_flush, bus.flush_arbiter, bus.capture_en);
        end
        bus.flush_complete = 2'b01;
        tick();
        bus.flush_complete = 2'b00;
        tick();
        total++;
        if (bus.capture_flush !== 2'b10) begin bad++; $display("FAIL basic_flush_seen got=%b want=10", bus.capture_flush); end
        bus.flush_complete = 2'b10;
        tick();
        bus.flush_complete = 2'b00;
        wait_done(10, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done got=no_pulse want=pulse"); end
        else if (got !== exp) begin
            bad++; $display("FAIL basic_result got pos=%0d tmo=%0b lnk=%0b want pos=%0d tmo=%0b lnk=%0b",
                            got.pos, got.tmo, got.lnk, exp.pos, exp.tmo, exp.lnk);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse got done=%0b busy=%0b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_and_mode();
        bit   ok;
        res_t got, exp;
        bus.trig_mode      = 1'b1;
        bus.trig_in        = 2'b01;
        bus.flush_complete = 2'b01;
        start(2'b01, 0, 0);
        exp_q.push_back(mk(2, 1'b0, 1'b0));
        wait_state(3'd3, 40, ok);
        tick();
        total++;
        if (!ok || bus.state !== 3'd4) begin bad++; $display("FAIL and_masked_trigger got=%0d want=4", bus.state); end
        wait_done(20, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL and_masked_result got ok=%0b pos=%0d want pos=%0d", ok, got.pos, exp.pos);
        end
        bus.flush_complete = 2'b11;
        start(2'b11, 0, 0);
        exp_q.push_back(mk(12, 1'b0, 1'b0));
        wait_state(3'd3, 40, ok);
        repeat (10) tick();
        total++;
        if (!ok || bus.state !== 3'd3) begin bad++; $display("FAIL and_partial_holds got=%0d want=3", bus.state); end
        bus.force_trig = 1'b1;
        tick();
        bus.force_trig = 1'b0;
        total++;
        if (bus.state !== 3'd4) begin bad++; $display("FAIL force_trigger got=%0d want=4", bus.state); end
        wait_done(20, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL force_result got ok=%0b pos=%0d want pos=%0d", ok, got.pos, exp.pos);
        end
        bus.trig_mode = 1'b0;
        bus.trig_in   = 2'b00;
    endtask

    task automatic test_arm_reject();
        bus.ram_ready  = 1'b0;
        bus.pod_enable = 2'b11;
        bus.arm        = 1'b1;
        repeat (5) tick();
        total++;
        if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reject_ram got state=%0d busy=%0b want 0/0", bus.state, bus.busy);
        end
        bus.ram_ready = 1'b1;
        bus.pod_ready = 2'b01;
        repeat (5) tick();
        total++;
        if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reject_pod_ready got state=%0d busy=%0b want 0/0", bus.state, bus.busy);
        end
        bus.pod_ready  = 2'b11;
        bus.pod_enable = 2'b00;
        repeat (5) tick();
        total++;
        if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reject_no_pods got state=%0d busy=%0b want 0/0", bus.state, bus.busy);
        end
        bus.arm = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit   ok;
        res_t got, exp;
        int   n;
        bus.flush_complete = 2'b00;
        bus.force_trig     = 1'b1;
        start(2'b11, 0, 0);
        exp_q.push_back(mk(2, 1'b1, 1'b0));
        wait_state(3'd5, 40, ok);
        n = 0;
        while (bus.state == 3'd5 && n < 200) begin n++; tick(); end
        total++;
        if (!ok || n != 64) begin bad++; $display("FAIL timeout_flush_cycles got=%0d want=64", n); end
        wait_done(10, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL timeout_result got ok=%0b pos=%0d tmo=%0b want pos=%0d tmo=1", ok, got.pos, got.tmo, exp.pos);
        end
        bus.flush_complete = 2'b11;
        tick();
        start(2'b11, 0, 0);
        total++;
        if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_cleared got=%0b want=0", bus.timeout_err); end
        exp_q.push_back(mk(2, 1'b0, 1'b0));
        wait_done(60, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL timeout_next_result got ok=%0b tmo=%0b want tmo=0", ok, got.tmo);
        end
        bus.force_trig = 1'b0;
    endtask

    task automatic test_abort();
        bit   ok, dn;
        res_t got, exp;
        bus.flush_complete = 2'b11;
        start(2'b11, 2, 5);
        exp_q.push_back(mk(0, 1'b0, 1'b0));
        wait_state(3'd3, 40, ok);
        bus.trig_in = 2'b11;
        bus.abort   = 1'b1;
        tick();
        bus.trig_in = 2'b00;
        bus.abort   = 1'b0;
        total++;
        if (!ok || bus.state !== 3'd5) begin bad++; $display("FAIL abort_beats_trigger got=%0d want=5", bus.state); end
        wait_done(20, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL abort_result got ok=%0b pos=%0d want pos=%0d", ok, got.pos, exp.pos);
        end
        tick();
        start(2'b11, 2, 5);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++;
        if (bus.state !== 3'd0) begin bad++; $display("FAIL abort_in_rst got=%0d want=0", bus.state); end
        dn = 1'b0;
        repeat (30) begin
            if (bus.done === 1'b1) dn = 1'b1;
            tick();
        end
        total++;
        if (dn !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_rst_no_done got done=%0b busy=%0b want 0/0", dn, bus.busy);
        end
    endtask

    task automatic test_link();
        bit   ok;
        res_t got, exp;
        bus.flush_complete = 2'b11;
        start(2'b11, 4, 5);
        exp_q.push_back(mk(0, 1'b0, 1'b1));
        wait_state(3'd3, 40, ok);
        bus.pod_ready = 2'b01;
        tick();
        bus.pod_ready = 2'b11;
        total++;
        if (!ok || bus.state !== 3'd5) begin bad++; $display("FAIL link_to_flush got=%0d want=5", bus.state); end
        wait_done(20, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL link_result got ok=%0b lnk=%0b want lnk=1", ok, got.lnk);
        end
    endtask

    task automatic test_reset_mid_post();
        bit   ok;
        res_t got, exp;
        bus.flush_complete = 2'b11;
        bus.force_trig     = 1'b1;
        tick();
        start(2'b11, 3, 20);
        wait_state(3'd4, 60, ok);
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        total++;
        if (!ok || out_vec() !== 64'd0) begin
            bad++; $display("FAIL midpost_reset got ok=%0b outputs=%h want 0", ok, out_vec());
        end
        #2 rst = 1'b0;
        repeat (2) tick();
        start(2'b11, 3, 2);
        exp_q.push_back(mk(4, 1'b0, 1'b0));
        total++;
        if (bus.trig_pos !== '0 || bus.state !== 3'd1) begin
            bad++; $display("FAIL midpost_rearm got pos=%0d state=%0d want 0/1", bus.trig_pos, bus.state);
        end
        wait_done(60, ok, got);
        exp = exp_q.pop_front();
        total++;
        if (!ok || got !== exp) begin
            bad++; $display("FAIL midpost_result got ok=%0b pos=%0d want pos=%0d", ok, got.pos, exp.pos);
        end
        bus.force_trig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_and_mode();
        test_arm_reject();
        test_timeout();
        test_abort();
        test_link();
        test_reset_mid_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=stalled want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
